// File: rtl/uart_xcvr.sv
// rtl/uart_xcvr.sv - parametrised full-duplex UART with internal prescalers, majority-vote RX and RX FIFO
module uart_xcvr #(
    parameter int OVS        = 16,
    parameter int DIV_W      = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] baud_div,
    input  logic [1:0]       cfg_len,
    input  logic             cfg_par_en,
    input  logic             cfg_par_even,
    input  logic             cfg_stop2,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             tx_out,
    input  logic             rx_in,
    output logic [7:0]       rx_data,
    output logic             rx_par_err,
    output logic             rx_frm_err,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             rx_ovf,
    input  logic             clr_err
);
    localparam int TKW = $clog2(OVS);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam logic [TKW-1:0] TK_LAST = TKW'(OVS - 1);
    localparam logic [TKW-1:0] TK_S0   = TKW'(OVS / 2 - 1);
    localparam logic [TKW-1:0] TK_S1   = TKW'(OVS / 2);
    localparam logic [TKW-1:0] TK_S2   = TKW'(OVS / 2 + 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

    // ---------------- TX ----------------
    state_t           tx_state, tx_next;
    logic [DIV_W-1:0] tx_cnt;
    logic [TKW-1:0]   tx_tk;
    logic [2:0]       tx_bit, tx_last;
    logic [7:0]       tx_sh, tx_masked;
    logic             tx_par_en, tx_stop2, tx_par;
    logic             tx_tick, tx_bit_end, tx_accept;

    assign tx_ready   = (tx_state == S_IDLE);
    assign tx_accept  = tx_valid && tx_ready;
    assign tx_tick    = (tx_cnt == baud_div);
    assign tx_bit_end = tx_tick && (tx_tk == TK_LAST);
    assign tx_masked  = tx_data & (8'hFF >> (2'd3 - cfg_len));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tx_state <= S_IDLE;
        else        tx_state <= tx_next;
    end

    always_comb begin
        tx_next = tx_state;
        tx_out  = 1'b1;
        case (tx_state)
            S_IDLE:  if (tx_accept) tx_next = S_START;
            S_START: begin
                tx_out = 1'b0;
                if (tx_bit_end) tx_next = S_DATA;
            end
            S_DATA: begin
                tx_out = tx_sh[0];
                if (tx_bit_end && tx_bit == tx_last) tx_next = tx_par_en ? S_PAR : S_STOP;
            end
            S_PAR: begin
                tx_out = tx_par;
                if (tx_bit_end) tx_next = S_STOP;
            end
            S_STOP:  if (tx_bit_end && (tx_bit[0] || !tx_stop2)) tx_next = S_IDLE;
            default: tx_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_cnt    <= '0;
            tx_tk     <= '0;
            tx_bit    <= '0;
            tx_last   <= '0;
            tx_sh     <= '0;
            tx_par_en <= 1'b0;
            tx_stop2  <= 1'b0;
            tx_par    <= 1'b0;
        end else if (tx_accept) begin
            tx_cnt    <= '0;
            tx_tk     <= '0;
            tx_bit    <= '0;
            tx_last   <= {1'b0, cfg_len} + 3'd4;
            tx_sh     <= tx_masked;
            tx_par_en <= cfg_par_en;
            tx_stop2  <= cfg_stop2;
            tx_par    <= (^tx_masked) ^ !cfg_par_even;
        end else begin
            tx_cnt <= tx_tick ? '0 : tx_cnt + DIV_W'(1);
            if (tx_tick) tx_tk <= (tx_tk == TK_LAST) ? '0 : tx_tk + TKW'(1);
            if (tx_bit_end) begin
                // tx_bit counts data bits in DATA and stop periods in STOP
                tx_bit <= (tx_next != tx_state) ? 3'd0 : tx_bit + 3'd1;
                if (tx_state == S_DATA) tx_sh <= tx_sh >> 1;
            end
        end
    end

    // ---------------- RX ----------------
    state_t           rx_state, rx_next;
    logic             rx_s1, rx_sync;
    logic [DIV_W-1:0] rx_cnt;
    logic [TKW-1:0]   rx_tk;
    logic [2:0]       rx_bit, rx_last;
    logic [7:0]       rx_sh;
    logic             rx_par_en, rx_par_even, rx_perr, rx_v0, rx_v1, rx_maj;
    logic             rx_tick, rx_decide, rx_bit_end, rx_start, push;

    assign rx_tick    = (rx_cnt == baud_div);
    assign rx_decide  = rx_tick && (rx_tk == TK_S2);
    assign rx_bit_end = rx_tick && (rx_tk == TK_LAST);
    assign rx_maj     = (rx_v0 & rx_v1) | (rx_v0 & rx_sync) | (rx_v1 & rx_sync);
    assign rx_start   = (rx_state == S_IDLE) && !rx_sync;
    assign push       = (rx_state == S_STOP) && rx_decide;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1    <= 1'b1;
            rx_sync  <= 1'b1;
            rx_state <= S_IDLE;
        end else begin
            rx_s1    <= rx_in;
            rx_sync  <= rx_s1;
            rx_state <= rx_next;
        end
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            S_IDLE:  if (rx_start) rx_next = S_START;
            S_START: begin
                if (rx_decide && rx_maj) rx_next = S_IDLE;
                else if (rx_bit_end)     rx_next = S_DATA;
            end
            S_DATA:  if (rx_bit_end && rx_bit == rx_last) rx_next = rx_par_en ? S_PAR : S_STOP;
            S_PAR:   if (rx_bit_end) rx_next = S_STOP;
            // leave STOP early so a back-to-back start edge is not missed
            S_STOP:  if (rx_decide) rx_next = S_IDLE;
            default: rx_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_cnt      <= '0;
            rx_tk       <= '0;
            rx_bit      <= '0;
            rx_last     <= '0;
            rx_sh       <= '0;
            rx_par_en   <= 1'b0;
            rx_par_even <= 1'b0;
            rx_perr     <= 1'b0;
            rx_v0       <= 1'b1;
            rx_v1       <= 1'b1;
        end else if (rx_start) begin
            rx_cnt      <= '0;
            rx_tk       <= '0;
            rx_bit      <= '0;
            rx_last     <= {1'b0, cfg_len} + 3'd4;
            rx_sh       <= '0;
            rx_par_en   <= cfg_par_en;
            rx_par_even <= cfg_par_even;
            rx_perr     <= 1'b0;
        end else begin
            rx_cnt <= rx_tick ? '0 : rx_cnt + DIV_W'(1);
            if (rx_tick) rx_tk <= (rx_tk == TK_LAST) ? '0 : rx_tk + TKW'(1);
            if (rx_tick && rx_tk == TK_S0) rx_v0 <= rx_sync;
            if (rx_tick && rx_tk == TK_S1) rx_v1 <= rx_sync;
            if (rx_decide && rx_state == S_DATA) rx_sh[rx_bit] <= rx_maj;
            if (rx_decide && rx_state == S_PAR)  rx_perr <= rx_maj ^ (^rx_sh) ^ !rx_par_even;
            if (rx_bit_end) rx_bit <= (rx_next != rx_state) ? 3'd0 : rx_bit + 3'd1;
        end
    end

    // ---------------- RX FIFO ----------------
    logic [9:0]  mem [FIFO_DEPTH];
    logic [9:0]  head;
    logic [AW:0] wr_ptr, rd_ptr;
    logic        empty, full, pop, wr_en;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = !empty && rx_ready;
    assign wr_en = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= {rx_sh, rx_perr, !rx_maj};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            rx_ovf <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)   rd_ptr <= rd_ptr + (AW+1)'(1);
            if (push && full && !pop) rx_ovf <= 1'b1;
            else if (clr_err)         rx_ovf <= 1'b0;
        end
    end

    assign head     = empty ? 10'd0 : mem[rd_ptr[AW-1:0]];
    assign rx_data    = head[9:2];
    assign rx_par_err = head[1];
    assign rx_frm_err = head[0];
    assign rx_valid   = !empty;
endmodule

// File: tb/tb_uart_xcvr.sv
// tb/tb_uart_xcvr.sv - self-checking bench for uart_xcvr with a bit-list frame model
module tb_uart_xcvr;
    localparam int OVS = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] baud_div = '0;
    logic [1:0]  cfg_len = 2'd3;
    logic        cfg_par_en = 1'b0, cfg_par_even = 1'b0, cfg_stop2 = 1'b0;
    logic [7:0]  tx_data = '0;
    logic        tx_valid = 1'b0;
    logic        tx_ready, tx_out;
    logic        rx_drv = 1'b1, loop = 1'b0;
    logic        rx_in_w;
    logic [7:0]  rx_data;
    logic        rx_par_err, rx_frm_err, rx_valid, rx_ovf;
    logic        rx_ready = 1'b0, clr_err = 1'b0;

    int passed = 0;
    int total  = 0;
    bit exp_bits[$];
    bit cap[$];

    assign rx_in_w = loop ? tx_out : rx_drv;

    uart_xcvr #(.OVS(OVS), .DIV_W(12), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .baud_div(baud_div), .cfg_len(cfg_len),
        .cfg_par_en(cfg_par_en), .cfg_par_even(cfg_par_even), .cfg_stop2(cfg_stop2),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_out(tx_out),
        .rx_in(rx_in_w), .rx_data(rx_data), .rx_par_err(rx_par_err), .rx_frm_err(rx_frm_err),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_ovf(rx_ovf), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    initial begin
        #(10 * 90000);
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

    function automatic logic [7:0] mask_of(input int len);
        return 8'((1 << len) - 1);
    endfunction

    function automatic bit par_of(input logic [7:0] d, input int len, input bit even);
        int ones;
        ones = $countones(d & mask_of(len));
        return even ? bit'(ones % 2) : bit'(1 - ones % 2);
    endfunction

    task automatic set_cfg(input int len, input bit pe, input bit ev, input bit s2, input int bd);
        cfg_len = 2'(len - 5);
        cfg_par_en = pe;
        cfg_par_even = ev;
        cfg_stop2 = s2;
        baud_div = 12'(bd);
    endtask

    task automatic build_frame(input logic [7:0] d, input int len, input bit pe, input bit ev,
                               input int nstop, input bit bad_par, input bit stop_val);
        exp_bits.delete();
        exp_bits.push_back(1'b0);
        for (int i = 0; i < len; i++) exp_bits.push_back(d[i]);
        if (pe) exp_bits.push_back(par_of(d, len, ev) ^ bad_par);
        for (int i = 0; i < nstop; i++) exp_bits.push_back(stop_val);
    endtask

    task automatic send_tx(input logic [7:0] d, output int low, output int bad);
        int period, w, idx;
        bit e;
        period = OVS * (int'(baud_div) + 1);
        w = 0;
        while (tx_ready !== 1'b1 && w < 5000) begin
            @(negedge clk);
            w++;
        end
        cap.delete();
        tx_data = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        low = 0;
        bad = 0;
        while (tx_ready === 1'b0 && low < 20000) begin
            idx = low / period;
            e = (idx < exp_bits.size()) ? exp_bits[idx] : 1'b1;
            if (tx_out !== e) bad++;
            if (low % period == period / 2) cap.push_back(tx_out);
            low++;
            @(negedge clk);
        end
    endtask

    task automatic inject(input int period);
        foreach (exp_bits[i]) begin
            rx_drv = exp_bits[i];
            repeat (period) @(negedge clk);
        end
        rx_drv = 1'b1;
        repeat (2 * period) @(negedge clk);
    endtask

    task automatic wait_rx();
        int w;
        w = 0;
        while (rx_valid !== 1'b1 && w < 5000) begin
            @(negedge clk);
            w++;
        end
    endtask

    task automatic pop_rx();
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({tx_out, tx_ready} !== 2'b11) $display("FAIL reset_tx got=%b exp=11", {tx_out, tx_ready});
        else passed++;
        total++;
        if ({rx_valid, rx_par_err, rx_frm_err, rx_ovf} !== 4'b0000)
            $display("FAIL reset_rx_flags got=%b exp=0000", {rx_valid, rx_par_err, rx_frm_err, rx_ovf});
        else passed++;
        total++;
        if (rx_data !== 8'h00) $display("FAIL reset_rx_data got=%h exp=00", rx_data);
        else passed++;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({tx_out, tx_ready, rx_valid, rx_ovf} !== 4'b1100)
            $display("FAIL post_reset got=%b exp=1100", {tx_out, tx_ready, rx_valid, rx_ovf});
        else passed++;
    endtask

    task automatic test_tx_8n1();
        int low, bad;
        set_cfg(8, 0, 0, 0, 0);
        loop = 1'b1;
        build_frame(8'hA5, 8, 0, 0, 1, 0, 1);
        send_tx(8'hA5, low, bad);
        total++;
        if (low !== 160) $display("FAIL tx8n1_ready_low got=%0d exp=160", low);
        else passed++;
        total++;
        if (bad !== 0) $display("FAIL tx8n1_wave bad_cycles=%0d exp=0", bad);
        else passed++;
        wait_rx();
        total++;
        if (rx_valid !== 1'b1) $display("FAIL lb8n1_valid got=%b exp=1", rx_valid);
        else passed++;
        total++;
        if ({rx_data, rx_par_err, rx_frm_err} !== {8'hA5, 2'b00})
            $display("FAIL lb8n1_entry got=%h/%b%b exp=a5/00", rx_data, rx_par_err, rx_frm_err);
        else passed++;
        pop_rx();
        total++;
        if (rx_valid !== 1'b0) $display("FAIL lb8n1_pop got=%b exp=0", rx_valid);
        else passed++;
    endtask

    task automatic test_7e2();
        int low, bad;
        set_cfg(7, 1, 1, 1, 2);
        loop = 1'b1;
        build_frame(8'h53, 7, 1, 1, 2, 0, 1);
        send_tx(8'h53, low, bad);
        total++;
        if (low !== 528) $display("FAIL tx7e2_len got=%0d exp=528", low);
        else passed++;
        total++;
        if (bad !== 0) $display("FAIL tx7e2_wave bad_cycles=%0d exp=0", bad);
        else passed++;
        total++;
        if (cap.size() < 9 || cap[8] !== 1'b0) $display("FAIL tx7e2_parity got=%0d samples exp parity 0", cap.size());
        else passed++;
        wait_rx();
        total++;
        if ({rx_valid, rx_data, rx_par_err, rx_frm_err} !== {1'b1, 8'h53, 2'b00})
            $display("FAIL lb7e2_entry got=%b/%h/%b%b exp=1/53/00", rx_valid, rx_data, rx_par_err, rx_frm_err);
        else passed++;
        pop_rx();
    endtask

    task automatic test_rx_errors();
        loop = 1'b0;
        set_cfg(8, 1, 0, 0, 0);
        build_frame(8'h0F, 8, 1, 0, 1, 1, 1);
        inject(OVS);
        wait_rx();
        total++;
        if ({rx_valid, rx_data, rx_par_err, rx_frm_err} !== {1'b1, 8'h0F, 2'b10})
            $display("FAIL rx_par_err got=%b/%h/%b%b exp=1/0f/10", rx_valid, rx_data, rx_par_err, rx_frm_err);
        else passed++;
        pop_rx();
        build_frame(8'h0F, 8, 1, 0, 1, 0, 0);
        inject(OVS);
        wait_rx();
        total++;
        if ({rx_valid, rx_data, rx_par_err, rx_frm_err} !== {1'b1, 8'h0F, 2'b01})
            $display("FAIL rx_frm_err got=%b/%h/%b%b exp=1/0f/01", rx_valid, rx_data, rx_par_err, rx_frm_err);
        else passed++;
        pop_rx();
    endtask

    task automatic test_false_start();
        loop = 1'b0;
        set_cfg(8, 0, 0, 0, 0);
        rx_drv = 1'b0;
        repeat (3) @(negedge clk);
        rx_drv = 1'b1;
        repeat (3 * OVS) @(negedge clk);
        total++;
        if (rx_valid !== 1'b0) $display("FAIL false_start_push got=%b exp=0", rx_valid);
        else passed++;
        build_frame(8'h3C, 8, 0, 0, 1, 0, 1);
        inject(OVS);
        wait_rx();
        total++;
        if ({rx_valid, rx_data, rx_par_err, rx_frm_err} !== {1'b1, 8'h3C, 2'b00})
            $display("FAIL after_false_start got=%b/%h/%b%b exp=1/3c/00", rx_valid, rx_data, rx_par_err, rx_frm_err);
        else passed++;
        pop_rx();
    endtask

    task automatic test_random_loopback();
        int len, bd, low, bad, exp_len;
        bit pe, ev, s2;
        logic [7:0] d;
        loop = 1'b1;
        for (int k = 0; k < 6; k++) begin
            len = 5 + int'($urandom_range(0, 3));
            bd  = int'($urandom_range(0, 2));
            pe  = bit'($urandom_range(0, 1));
            ev  = bit'($urandom_range(0, 1));
            s2  = bit'($urandom_range(0, 1));
            d   = 8'($urandom);
            set_cfg(len, pe, ev, s2, bd);
            build_frame(d, len, pe, ev, s2 ? 2 : 1, 0, 1);
            exp_len = (1 + len + int'(pe) + 1 + int'(s2)) * OVS * (bd + 1);
            send_tx(d, low, bad);
            total++;
            if (low !== exp_len) $display("FAIL rnd_tx_len[%0d] got=%0d exp=%0d", k, low, exp_len);
            else passed++;
            total++;
            if (bad !== 0) $display("FAIL rnd_tx_wave[%0d] bad_cycles=%0d exp=0", k, bad);
            else passed++;
            wait_rx();
            total++;
            if ({rx_valid, rx_data, rx_par_err, rx_frm_err} !== {1'b1, d & mask_of(len), 2'b00})
                $display("FAIL rnd_lb[%0d] got=%b/%h/%b%b exp=1/%h/00", k, rx_valid, rx_data,
                         rx_par_err, rx_frm_err, d & mask_of(len));
            else passed++;
            pop_rx();
        end
    endtask

    task automatic test_random_inject();
        int len, bd;
        bit pe, ev, bp, sv;
        logic [7:0] d;
        loop = 1'b0;
        for (int k = 0; k < 6; k++) begin
            len = 5 + int'($urandom_range(0, 3));
            bd  = int'($urandom_range(0, 2));
            pe  = bit'($urandom_range(0, 1));
            ev  = bit'($urandom_range(0, 1));
            bp  = pe & bit'($urandom_range(0, 1));
            sv  = bit'($urandom_range(0, 1));
            d   = 8'($urandom);
            set_cfg(len, pe, ev, 0, bd);
            build_frame(d, len, pe, ev, 1, bp, sv);
            inject(OVS * (bd + 1));
            wait_rx();
            total++;
            if ({rx_valid, rx_data, rx_par_err, rx_frm_err} !== {1'b1, d & mask_of(len), bp, !sv})
                $display("FAIL rnd_inj[%0d] got=%b/%h/%b%b exp=1/%h/%b%b", k, rx_valid, rx_data,
                         rx_par_err, rx_frm_err, d & mask_of(len), bp, !sv);
            else passed++;
            pop_rx();
        end
    endtask

    task automatic test_overflow();
        loop = 1'b0;
        set_cfg(8, 0, 0, 0, 0);
        for (int k = 1; k <= 5; k++) begin
            build_frame(8'(k), 8, 0, 0, 1, 0, 1);
            inject(OVS);
        end
        total++;
        if ({rx_ovf, rx_valid, rx_data} !== {2'b11, 8'h01})
            $display("FAIL ovf_set got=%b%b/%h exp=11/01", rx_ovf, rx_valid, rx_data);
        else passed++;
        for (int k = 1; k <= 4; k++) begin
            total++;
            if ({rx_valid, rx_data, rx_par_err, rx_frm_err} !== {1'b1, 8'(k), 2'b00})
                $display("FAIL ovf_drain[%0d] got=%b/%h exp=1/%h", k, rx_valid, rx_data, 8'(k));
            else passed++;
            pop_rx();
        end
        total++;
        if ({rx_valid, rx_ovf} !== 2'b01) $display("FAIL ovf_empty_sticky got=%b exp=01", {rx_valid, rx_ovf});
        else passed++;
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        total++;
        if (rx_ovf !== 1'b0) $display("FAIL ovf_clear got=%b exp=0", rx_ovf);
        else passed++;
    endtask

    task automatic test_reset_mid_tx();
        set_cfg(8, 0, 0, 0, 1);
        loop = 1'b1;
        tx_data = 8'h00;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (200) @(negedge clk);
        total++;
        if ({tx_ready, tx_out} !== 2'b00) $display("FAIL mid_tx_busy got=%b exp=00", {tx_ready, tx_out});
        else passed++;
        rst_n = 1'b0;
        #1;
        total++;
        if ({tx_out, tx_ready} !== 2'b11) $display("FAIL mid_tx_reset got=%b exp=11", {tx_out, tx_ready});
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4 * OVS * 2) @(negedge clk);
        total++;
        if ({rx_valid, tx_ready, tx_out} !== 3'b011)
            $display("FAIL mid_tx_after got=%b exp=011", {rx_valid, tx_ready, tx_out});
        else passed++;
    endtask

    initial begin
        test_reset();
        test_tx_8n1();
        test_7e2();
        test_rx_errors();
        test_false_start();
        test_random_loopback();
        test_random_inject();
        test_overflow();
        test_reset_mid_tx();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
